// File: rtl/bram_fifo.sv
// bram_fifo: first-word-fall-through FIFO built on an inferred simple-dual-port
// block RAM with registered read.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   flush        synchronous clear of contents, active-high
//   s_data       write word
//   s_valid      write request
//   s_ready      FIFO can accept a word this cycle (count < DEPTH)
//   m_data       head word (first-word-fall-through)
//   m_valid      m_data holds a valid head word
//   m_ready      consumer accepts the head word
//   count        words accepted and not yet popped (includes in-flight words)
//   almost_full  registered, count >= AF_LEVEL
//   almost_empty registered, count <= AE_LEVEL
module bram_fifo #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Pointers carry one extra bit so RAM-full and RAM-empty are distinct.
    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;

    logic                  r_s1_valid;   // r_rd_data holds an unconsumed word
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_af;
    logic                  r_ae;

    logic                  w_s_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ram_nonempty;
    logic                  w_s2_load;
    logic                  w_rd_en;

    assign w_s_ready      = (r_count < C_DEPTH);
    assign w_push         = rst_n && !flush && s_valid && w_s_ready;
    assign w_pop          = rst_n && !flush && r_m_valid && m_ready;
    assign w_ram_nonempty = (r_wr_ptr != r_rd_ptr);

    // Output register takes the RAM read register when it is empty or
    // being consumed this cycle; the RAM is read when its read register is
    // empty or draining, giving one push and one pop per cycle without bubbles.
    assign w_s2_load = r_s1_valid && (!r_m_valid || m_ready);
    assign w_rd_en   = rst_n && !flush && w_ram_nonempty && (!r_s1_valid || w_s2_load);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Block RAM: no reset on the array or its read register. Occupancy never
    // lets a write target an unread address, so read-during-write is moot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= s_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_s1_valid <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_s1_valid <= 1'b0;
            r_m_valid  <= 1'b0;
            r_af       <= (C_AF == '0);
            r_ae       <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + C_ONE;
            end
            r_count <= w_count_nxt;
            r_af    <= (w_count_nxt >= C_AF);
            r_ae    <= (w_count_nxt <= C_AE);

            if (w_rd_en) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_rd_data;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready      = w_s_ready;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign count        = r_count;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

endmodule
